// File: rtl/dense_layer_ctrl.sv
// dense_layer_ctrl: frame sequencer for one fixed-point dense layer.
// Issues NUM_CYC shared ROM/buffer reads, delays the read strobe into the
// layer's vld_in, waits out the layer pipeline, captures the result once and
// hands it downstream over a valid/ready handshake.
module dense_layer_ctrl #(
  parameter int INPUT_SIZE  = 4,
  parameter int NUM_CYC     = 512,
  parameter int BW          = 16,
  parameter int OUTPUT_SIZE = 128,
  parameter int RD_LAT      = 1,
  parameter int PIPE_LAT    = $clog2(INPUT_SIZE) + 3
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_frame_rdy,
  input  logic                         i_en,
  output logic                         o_frame_done,
  output logic                         o_rd_en,
  output logic [$clog2(NUM_CYC)-1:0]   o_rd_addr,
  output logic                         o_layer_vld_in,
  input  logic                         i_layer_vld_out,
  input  logic [OUTPUT_SIZE*BW-1:0]    i_layer_data,
  output logic                         o_out_vld,
  input  logic                         i_out_rdy,
  output logic [OUTPUT_SIZE*BW-1:0]    o_out_data,
  output logic                         o_busy,
  output logic                         o_err
);

  localparam int AW       = $clog2(NUM_CYC);
  // Counting down from RD_LAT+PIPE_LAT-1 lands on the cycle in which the
  // layer presents the result of the final strobe.
  localparam int CNT_LOAD = RD_LAT + PIPE_LAT - 1;
  localparam int CW       = $clog2(CNT_LOAD + 1) + 1;
  localparam logic [AW-1:0] ADDR_LAST = AW'(NUM_CYC - 1);
  localparam logic [CW-1:0] CNT_INIT  = CW'(CNT_LOAD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [AW-1:0]               r_rd_addr;
  logic [CW-1:0]               r_cnt;
  logic [RD_LAT-1:0]           r_vld_sr;
  logic                        r_out_vld;
  logic                        r_err;
  logic [OUTPUT_SIZE*BW-1:0]   r_out_data;

  logic w_rd_en;
  logic w_last_issue;
  logic w_capture;
  logic w_accept;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decode plus the per-cycle strobes that depend on the state.
  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_last_issue = 1'b0;
    w_capture    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_frame_rdy) w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_rd_en      = i_en;
        w_last_issue = i_en && (r_rd_addr == ADDR_LAST);
        if (w_last_issue) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_capture = (r_cnt == '0);
        if (w_capture) w_state_next = S_HOLD;
      end
      S_HOLD: begin
        w_accept = r_out_vld && i_out_rdy;
        if (w_accept) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Read address: advances on every issued read, wraps to 0 after the last.
  always_ff @(posedge i_clk) begin
    if (i_rst || r_state == S_IDLE) r_rd_addr <= '0;
    else if (w_last_issue)          r_rd_addr <= '0;
    else if (w_rd_en)               r_rd_addr <= r_rd_addr + 1'b1;
  end

  // Drain counter: loaded on the final issue, counts down to the capture cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                   r_cnt <= '0;
    else if (w_last_issue)                       r_cnt <= CNT_INIT;
    else if (r_state == S_DRAIN && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end

  // Read-latency delay line turning rd_en into the layer's vld_in; it runs in
  // every state so the last RD_LAT strobes leave during DRAIN.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_sr <= '0;
    end else begin
      r_vld_sr[0] <= w_rd_en;
      for (int i = 1; i < RD_LAT; i++) r_vld_sr[i] <= r_vld_sr[i-1];
    end
  end

  // Result holding register and its valid flag; only the capture cycle loads.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_data <= '0;
      r_out_vld  <= 1'b0;
    end else if (w_capture) begin
      r_out_data <= i_layer_data;
      r_out_vld  <= 1'b1;
    end else if (w_accept) begin
      r_out_vld  <= 1'b0;
    end
  end

  // Sticky error: the layer did not flag a valid result on the capture cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst)                             r_err <= 1'b0;
    else if (w_capture && !i_layer_vld_out) r_err <= 1'b1;
  end

  assign o_rd_en        = w_rd_en;
  assign o_rd_addr      = r_rd_addr;
  assign o_frame_done   = w_last_issue;
  assign o_layer_vld_in = r_vld_sr[RD_LAT-1];
  assign o_out_vld      = r_out_vld;
  assign o_out_data     = r_out_data;
  assign o_busy         = (r_state != S_IDLE);
  assign o_err          = r_err;

endmodule

// File: tb/tb_dense_layer_ctrl.sv
// tb_dense_layer_ctrl: directed bench for dense_layer_ctrl. Two instances share
// stimulus: u_dut1 with RD_LAT=1 and u_dut3 with RD_LAT=3, each driven by a
// small layer model that echoes every vld_in PIPE_LAT cycles later and only
// presents the real result for the final strobe of a frame.
module tb_dense_layer_ctrl;

  localparam int NC = 8;
  localparam int BW = 16;
  localparam int OS = 4;
  localparam int PL = 5;
  localparam int AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, frame_rdy, en, out_rdy, withhold;
  logic [15:0] pat;
  bit          sel;

  int total = 0;
  int bad   = 0;

  logic          fd1, rden1, vin1, vout1, ovld1, busy1, err1;
  logic [AW-1:0] addr1;
  logic [63:0]   ldata1, odata1;
  logic          fd3, rden3, vin3, vout3, ovld3, busy3, err3;
  logic [AW-1:0] addr3;
  logic [63:0]   ldata3, odata3;

  dense_layer_ctrl #(.INPUT_SIZE(4), .NUM_CYC(NC), .BW(BW), .OUTPUT_SIZE(OS),
                     .RD_LAT(1), .PIPE_LAT(PL)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_frame_rdy(frame_rdy), .i_en(en),
    .o_frame_done(fd1), .o_rd_en(rden1), .o_rd_addr(addr1),
    .o_layer_vld_in(vin1), .i_layer_vld_out(vout1), .i_layer_data(ldata1),
    .o_out_vld(ovld1), .i_out_rdy(out_rdy), .o_out_data(odata1),
    .o_busy(busy1), .o_err(err1));

  dense_layer_ctrl #(.INPUT_SIZE(4), .NUM_CYC(NC), .BW(BW), .OUTPUT_SIZE(OS),
                     .RD_LAT(3), .PIPE_LAT(PL)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_frame_rdy(frame_rdy), .i_en(en),
    .o_frame_done(fd3), .o_rd_en(rden3), .o_rd_addr(addr3),
    .o_layer_vld_in(vin3), .i_layer_vld_out(vout3), .i_layer_data(ldata3),
    .o_out_vld(ovld3), .i_out_rdy(out_rdy), .o_out_data(odata3),
    .o_busy(busy3), .o_err(err3));

  // Layer models: vld_out echoes each vld_in after PL cycles; real data only
  // for the NC-th strobe of a frame, junk for the early partial pulses.
  logic [PL-1:0] msr1, mfin1, msr3, mfin3;
  int            mcnt1, mcnt3;

  always_ff @(posedge clk) begin
    if (rst) begin
      msr1 <= '0; mfin1 <= '0; mcnt1 <= 0;
    end else begin
      msr1  <= {msr1[PL-2:0], vin1};
      mfin1 <= {mfin1[PL-2:0], vin1 && (mcnt1 == NC-1)};
      if (vin1) mcnt1 <= (mcnt1 == NC-1) ? 0 : mcnt1 + 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msr3 <= '0; mfin3 <= '0; mcnt3 <= 0;
    end else begin
      msr3  <= {msr3[PL-2:0], vin3};
      mfin3 <= {mfin3[PL-2:0], vin3 && (mcnt3 == NC-1)};
      if (vin3) mcnt3 <= (mcnt3 == NC-1) ? 0 : mcnt3 + 1;
    end
  end

  assign vout1  = msr1[PL-1] & ~withhold;
  assign ldata1 = mfin1[PL-1] ? {OS{pat}} : {OS{16'hDEAD}};
  assign vout3  = msr3[PL-1] & ~withhold;
  assign ldata3 = mfin3[PL-1] ? {OS{pat}} : {OS{16'hDEAD}};

  // Selected-instance view used by run_frame.
  logic          s_rden, s_vin, s_fd, s_ovld;
  logic [AW-1:0] s_addr;
  assign s_rden = sel ? rden3 : rden1;
  assign s_vin  = sel ? vin3  : vin1;
  assign s_fd   = sel ? fd3   : fd1;
  assign s_ovld = sel ? ovld3 : ovld1;
  assign s_addr = sel ? addr3 : addr1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one frame from IDLE until out_vld is first seen (bounded). Inputs are
  // driven 1ns after the rising edge, outputs sampled at the falling edge.
  task automatic run_frame(input bit keep_rdy, input int stall_addr, input int stall_len,
                           output int n_rd, output int n_vin, output int n_fd,
                           output int fd_addr, output int addr_bad, output int lag_bad,
                           output int lat, output bit tmo);
    int idx, last_rd, exp_a, stall_rem, rl;
    logic [127:0] hist;
    bit done;
    rl = sel ? 3 : 1;
    n_rd = 0; n_vin = 0; n_fd = 0; fd_addr = -1; addr_bad = 0; lag_bad = 0;
    lat = -1; tmo = 1'b0; idx = 0; last_rd = 0; exp_a = 0; stall_rem = 0;
    hist = '0; done = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      frame_rdy = (idx == 0) || keep_rdy;
      if (stall_rem > 0) begin en = 1'b0; stall_rem--; end
      else en = 1'b1;
      @(negedge clk);
      hist[idx] = s_rden;
      if (s_rden) begin
        n_rd++;
        if (s_addr !== AW'(exp_a)) addr_bad++;
        exp_a++;
        last_rd = idx;
        if (int'(s_addr) == stall_addr) stall_rem = stall_len;
      end
      if (s_fd) begin n_fd++; fd_addr = int'(s_addr); end
      if (s_vin) n_vin++;
      if (s_vin !== ((idx >= rl) ? hist[idx-rl] : 1'b0)) lag_bad++;
      if (s_ovld) begin lat = idx - last_rd; done = 1'b1; end
      idx++;
      if (!done && idx >= 120) begin tmo = 1'b1; done = 1'b1; end
    end
  endtask

  initial begin
    int n_rd, n_vin, n_fd, fd_addr, addr_bad, lag_bad, lat, viol, guard;
    bit tmo;
    rst = 1'b1; frame_rdy = 1'b0; en = 1'b1; out_rdy = 1'b1;
    withhold = 1'b0; pat = 16'h0; sel = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_strobes", {rden1, vin1, fd1, ovld1, busy1, err1}, 6'b0);
    chk("rst_addr", addr1, 0);
    chk("rst_data", odata1, 64'h0);
    rst = 1'b0;

    // Plain frame: capture edge at last rd_en + RD_LAT + PIPE_LAT, out_vld
    // visible the cycle after, so 1+5+1 samples later.
    pat = 16'h0A01;
    run_frame(1'b0, -1, 0, n_rd, n_vin, n_fd, fd_addr, addr_bad, lag_bad, lat, tmo);
    chk("f1_timeout", tmo, 0);
    chk("f1_rd_cnt", n_rd, 8);
    chk("f1_addr_seq", addr_bad, 0);
    chk("f1_fd_cnt", n_fd, 1);
    chk("f1_fd_addr", fd_addr, 7);
    chk("f1_vin_cnt", n_vin, 8);
    chk("f1_vin_lag", lag_bad, 0);
    chk("f1_latency", lat, 7);
    chk("f1_data", odata1, 64'h0A01_0A01_0A01_0A01);
    chk("f1_err", err1, 0);
    @(posedge clk); #1; @(negedge clk);
    chk("f1_accept", {ovld1, busy1}, 2'b00);

    // Stall of 3 cycles after address 6.
    pat = 16'h1234;
    run_frame(1'b0, 6, 3, n_rd, n_vin, n_fd, fd_addr, addr_bad, lag_bad, lat, tmo);
    chk("f2_timeout", tmo, 0);
    chk("f2_rd_cnt", n_rd, 8);
    chk("f2_addr_seq", addr_bad, 0);
    chk("f2_vin_cnt", n_vin, 8);
    chk("f2_vin_lag", lag_bad, 0);
    chk("f2_latency", lat, 7);
    chk("f2_data", odata1, 64'h1234_1234_1234_1234);
    chk("f2_err", err1, 0);

    // Downstream back-pressure for 10 cycles with frame_rdy held high.
    @(posedge clk); #1; out_rdy = 1'b0;
    pat = 16'h5A5A;
    run_frame(1'b1, -1, 0, n_rd, n_vin, n_fd, fd_addr, addr_bad, lag_bad, lat, tmo);
    chk("f3_timeout", tmo, 0);
    chk("f3_data", odata1, 64'h5A5A_5A5A_5A5A_5A5A);
    pat = 16'h7777;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1; frame_rdy = 1'b1;
      @(negedge clk);
      if (ovld1 !== 1'b1 || odata1 !== 64'h5A5A_5A5A_5A5A_5A5A ||
          rden1 !== 1'b0 || busy1 !== 1'b1) viol++;
    end
    chk("f3_hold_stable", viol, 0);
    @(posedge clk); #1; out_rdy = 1'b1;
    @(negedge clk);
    chk("f3_vld_at_rdy", ovld1, 1);
    @(posedge clk); #1; @(negedge clk);
    chk("f3_idle_gap", {ovld1, rden1}, 2'b00);
    @(posedge clk); #1; frame_rdy = 1'b0; @(negedge clk);
    chk("f3_restart", {rden1, addr1}, {1'b1, 3'd0});

    // Reset while address 4 is being issued.
    guard = 0;
    while (!(rden1 === 1'b1 && addr1 === 3'd4) && guard < 10) begin
      @(posedge clk); #1; @(negedge clk);
      guard++;
    end
    chk("f5_reach_addr4", addr1, 4);
    rst = 1'b1;
    @(posedge clk); #1; @(negedge clk);
    chk("f5_rst_outputs", {rden1, vin1, fd1, ovld1, busy1, err1, addr1}, 9'b0);
    rst = 1'b0;
    pat = 16'h0C0C;
    run_frame(1'b0, -1, 0, n_rd, n_vin, n_fd, fd_addr, addr_bad, lag_bad, lat, tmo);
    chk("f5_timeout", tmo, 0);
    chk("f5_rd_cnt", n_rd, 8);
    chk("f5_addr_seq", addr_bad, 0);
    chk("f5_vin_cnt", n_vin, 8);
    chk("f5_data", odata1, 64'h0C0C_0C0C_0C0C_0C0C);

    // Layer withholds vld_out at capture: sticky err until reset.
    withhold = 1'b1;
    pat = 16'h0D0D;
    run_frame(1'b0, -1, 0, n_rd, n_vin, n_fd, fd_addr, addr_bad, lag_bad, lat, tmo);
    chk("f4_timeout", tmo, 0);
    chk("f4_err_set", err1, 1);
    chk("f4_data", odata1, 64'h0D0D_0D0D_0D0D_0D0D);
    withhold = 1'b0;
    pat = 16'h0E0E;
    run_frame(1'b0, -1, 0, n_rd, n_vin, n_fd, fd_addr, addr_bad, lag_bad, lat, tmo);
    chk("f4_err_sticky", err1, 1);
    chk("f4_data2", odata1, 64'h0E0E_0E0E_0E0E_0E0E);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("f4_err_cleared", err1, 0);

    // Back-to-back frames on the RD_LAT=3 instance.
    sel = 1'b1;
    for (int f = 0; f < 2; f++) begin
      pat = (f == 0) ? 16'hB0B0 : 16'hB1B1;
      run_frame(1'b1, -1, 0, n_rd, n_vin, n_fd, fd_addr, addr_bad, lag_bad, lat, tmo);
      chk($sformatf("b2b%0d_timeout", f), tmo, 0);
      chk($sformatf("b2b%0d_rd_cnt", f), n_rd, 8);
      chk($sformatf("b2b%0d_fd_cnt", f), n_fd, 1);
      chk($sformatf("b2b%0d_vin_cnt", f), n_vin, 8);
      chk($sformatf("b2b%0d_vin_lag3", f), lag_bad, 0);
      chk($sformatf("b2b%0d_latency", f), lat, 3 + PL + 1);
      chk($sformatf("b2b%0d_data", f), odata3, {OS{pat}});
    end
    @(posedge clk); #1; frame_rdy = 1'b0;
    @(negedge clk);
    chk("b2b_final_accept", {ovld3, busy3}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
